// File: rtl/fc_mem_arbiter_if.sv
// Signal bundle between the burst requesters, the shared memory read port and fc_mem_arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface fc_mem_arbiter_if #(
  parameter int NUM_REQ           = 2,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH       = 8
);
  logic [NUM_REQ-1:0]                   req;
  logic [NUM_REQ*MEM_ADDRESS_WIDTH-1:0] req_addr;
  logic [NUM_REQ*COUNT_WIDTH-1:0]       req_count;
  logic [NUM_REQ-1:0]                   grant;
  logic [NUM_REQ-1:0]                   data_valid;
  logic [WORD_SIZE-1:0]                 data;
  logic [NUM_REQ-1:0]                   burst_done;
  logic                                 busy;
  logic [MEM_ADDRESS_WIDTH-1:0]         mem_addr;
  logic [WORD_SIZE-1:0]                 mem_data;

  modport master (
    output req, req_addr, req_count, mem_data,
    input  grant, data_valid, data, burst_done, busy, mem_addr
  );

  modport slave (
    input  req, req_addr, req_count, mem_data,
    output grant, data_valid, data, burst_done, busy, mem_addr
  );
endinterface

// File: rtl/fc_mem_arbiter.sv
// Round-robin arbiter sharing one weight/bias memory read port between NUM_REQ burst requesters.
// A granted burst streams base..base+count-1 and is never preempted; one idle cycle separates bursts.
module fc_mem_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 10,
  parameter int COUNT_WIDTH       = 8
) (
  input logic              clk,
  input logic              rst,
  fc_mem_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                   state_reg;
  logic [IDX_W-1:0]             last_owner_reg;
  logic [COUNT_WIDTH-1:0]       remaining_reg;
  logic [NUM_REQ-1:0]           grant_reg;
  logic [NUM_REQ-1:0]           valid_reg;
  logic [NUM_REQ-1:0]           done_reg;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_reg;

  logic [MEM_ADDRESS_WIDTH-1:0] base_arr  [NUM_REQ];
  logic [COUNT_WIDTH-1:0]       count_arr [NUM_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [NUM_REQ-1:0] owner_onehot;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign base_arr[gi]  = bus.req_addr[gi*MEM_ADDRESS_WIDTH +: MEM_ADDRESS_WIDTH];
      assign count_arr[gi] = bus.req_count[gi*COUNT_WIDTH +: COUNT_WIDTH];
    end
  endgenerate

  // Walk offsets from farthest to nearest so the requester closest after last_owner wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(last_owner_reg) + k) % NUM_REQ);
      if (bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_owner_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_owner_reg <= IDX_W'(NUM_REQ - 1);
      remaining_reg  <= '0;
      grant_reg      <= '0;
      valid_reg      <= '0;
      done_reg       <= '0;
      addr_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          grant_reg <= '0;
          valid_reg <= '0;
          done_reg  <= '0;
          if (win_found) begin
            last_owner_reg <= win_idx;
            grant_reg      <= win_onehot;
            // A zero-length burst skips straight to the single completion cycle.
            if (count_arr[win_idx] == '0) begin
              state_reg <= ST_DRAIN;
              done_reg  <= win_onehot;
            end else begin
              state_reg     <= ST_BURST;
              addr_reg      <= base_arr[win_idx];
              remaining_reg <= count_arr[win_idx] - COUNT_WIDTH'(1);
            end
          end
        end
        ST_BURST: begin
          valid_reg <= owner_onehot;
          if (remaining_reg == '0) begin
            state_reg <= ST_DRAIN;
            done_reg  <= owner_onehot;
          end else begin
            addr_reg      <= addr_reg + MEM_ADDRESS_WIDTH'(1);
            remaining_reg <= remaining_reg - COUNT_WIDTH'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          grant_reg <= '0;
          valid_reg <= '0;
          done_reg  <= '0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.data_valid = valid_reg;
  assign bus.burst_done = done_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.mem_addr   = addr_reg;
  assign bus.data       = bus.mem_data;
endmodule

// File: tb/tb_fc_mem_arbiter.sv
// Self-checking bench for fc_mem_arbiter: a transaction-level model of round-robin bursts
// produces the expected per-cycle outputs, which each scenario task compares inline.
module tb_fc_mem_arbiter;
  localparam int NR = 3, WS = 16, AW = 10, CW = 8, MAXC = 256;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fc_mem_arbiter_if #(.NUM_REQ(NR), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  fc_mem_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .MEM_ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Memory holds word == address and answers one cycle after the address.
  always @(posedge clk) bus.mem_data <= WS'(bus.mem_addr);

  // Stimulus description for one transaction set
  logic [NR-1:0] t_mask;
  logic [AW-1:0] t_addr [NR];
  int            t_count [NR];
  bit            t_hold;
  int            t_bursts;
  int            t_chg;

  // Model state carried across transaction sets
  int            m_last;
  logic [AW-1:0] m_addr;

  logic [NR-1:0] e_grant [MAXC], e_valid [MAXC], e_done [MAXC];
  logic [NR-1:0] o_grant [MAXC], o_valid [MAXC], o_done [MAXC];
  logic          e_busy [MAXC], o_busy [MAXC];
  logic [AW-1:0] e_addr [MAXC], o_addr [MAXC];
  logic [WS-1:0] e_data [MAXC], o_data [MAXC];
  int            e_drop [NR];
  int            e_len;

  task automatic set_stim(input logic [NR-1:0] mask, input bit hold, input int bursts, input int chg);
    t_mask = mask; t_hold = hold; t_bursts = bursts; t_chg = chg;
  endtask

  // Cycle 0 is the arbitration cycle in which requests are first seen.
  task automatic model_run();
    logic [NR-1:0] pend;
    logic [AW-1:0] ad;
    int a, w, n, done, served;
    pend = t_mask; a = 0; served = 0;
    for (int j = 0; j < MAXC; j++) begin
      e_grant[j] = '0; e_valid[j] = '0; e_done[j] = '0;
      e_busy[j] = 1'b0; e_addr[j] = m_addr; e_data[j] = '0;
    end
    for (int i = 0; i < NR; i++) e_drop[i] = -1;
    while (pend != '0 && served < t_bursts) begin
      w = -1;
      for (int k = 1; k <= NR; k++)
        if (w < 0 && pend[(m_last + k) % NR]) w = (m_last + k) % NR;
      n = t_count[w];
      done = a + n + 1;
      for (int j = a + 1; j <= done; j++) begin e_grant[j][w] = 1'b1; e_busy[j] = 1'b1; end
      for (int k = 1; k <= n; k++) begin
        ad = AW'((int'(t_addr[w]) + k - 1) % (1 << AW));
        for (int j = a + k; j < MAXC; j++) e_addr[j] = ad;
        e_valid[a + 1 + k][w] = 1'b1;
        e_data[a + 1 + k] = WS'(ad);
        m_addr = ad;
      end
      e_done[done][w] = 1'b1;
      e_drop[w] = done;
      m_last = w;
      if (!t_hold) pend[w] = 1'b0;
      a = done + 1;
      served++;
    end
    e_len = a + 1;
  endtask

  task automatic run_stim();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i*AW +: AW]  = t_addr[i];
      bus.req_count[i*CW +: CW] = CW'(t_count[i]);
    end
    bus.req = t_mask;
    o_grant[0] = '0;
    for (int j = 1; j <= e_len; j++) begin
      @(negedge clk);
      o_grant[j] = bus.grant; o_valid[j] = bus.data_valid; o_done[j] = bus.burst_done;
      o_busy[j] = bus.busy; o_addr[j] = bus.mem_addr; o_data[j] = bus.data;
      for (int i = 0; i < NR; i++) if (e_drop[i] == j) bus.req[i] = 1'b0;
      if (j == t_chg) begin
        bus.req       = '0;
        bus.req_addr  = ~bus.req_addr;
        bus.req_count = bus.req_count ^ {(NR*CW){1'b1}};
      end
    end
    bus.req = '0;
    $display("txn mask=%b hold=%0d bursts<=%0d cycles=%0d", t_mask, t_hold, t_bursts, e_len);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '1; bus.req_addr = '1; bus.req_count = '1;
    repeat (3) @(negedge clk);
    checks++; if (bus.grant !== '0)      begin errors++; $display("FAIL reset_grant got=%h want=0", bus.grant); end
    checks++; if (bus.data_valid !== '0) begin errors++; $display("FAIL reset_valid got=%h want=0", bus.data_valid); end
    checks++; if (bus.burst_done !== '0) begin errors++; $display("FAIL reset_done got=%h want=0", bus.burst_done); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.mem_addr !== '0)   begin errors++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr); end
    bus.req = '0;
    rst = 1'b0;
    m_last = NR - 1; m_addr = '0;
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[4] = '{0, 1, 0, 1};
    set_stim(3'b011, 1'b1, 4, -1);
    t_addr[0] = 10'h100; t_addr[1] = 10'h200; t_addr[2] = 10'h300;
    t_count[0] = 2; t_count[1] = 2; t_count[2] = 5;
    model_run(); run_stim();
    for (int j = 1; j <= e_len; j++) begin
      checks++;
      if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
        errors++;
        $display("FAIL rr cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", j,
                 o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
      end
      if (o_grant[j] != '0 && o_grant[j-1] == '0) order.push_back($clog2(o_grant[j]));
    end
    checks++;
    if (order.size() != 4) begin errors++; $display("FAIL rr_count got=%0d want=4", order.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (order[i] != exp_order[i]) begin errors++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, order[i], exp_order[i]); end
    end
  endtask

  task automatic test_single_burst();
    int nvalid = 0;
    set_stim(3'b001, 1'b0, NR, -1);
    t_addr[0] = 10'h010; t_addr[1] = 10'h0AA; t_addr[2] = 10'h0BB;
    t_count[0] = 4; t_count[1] = 9; t_count[2] = 9;
    model_run(); run_stim();
    for (int j = 1; j <= e_len; j++) begin
      checks++;
      if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
        errors++;
        $display("FAIL single cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", j,
                 o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
      end
      if (e_valid[j] != '0) begin
        checks++;
        if (o_data[j] !== e_data[j]) begin errors++; $display("FAIL single_data cyc=%0d got=%h want=%h", j, o_data[j], e_data[j]); end
      end
      if (o_valid[j] == 3'b001) nvalid++;
    end
    checks++; if (nvalid != 4) begin errors++; $display("FAIL single_nvalid got=%0d want=4", nvalid); end
  endtask

  task automatic test_addr_wrap();
    int nvalid = 0;
    set_stim(3'b001, 1'b0, NR, -1);
    t_addr[0] = 10'h3FE; t_count[0] = 4;
    model_run(); run_stim();
    for (int j = 1; j <= e_len; j++) begin
      checks++;
      if ({o_grant[j], o_valid[j], o_done[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_addr[j]}) begin
        errors++;
        $display("FAIL wrap cyc=%0d grant/valid/done/addr got=%h/%h/%h/%h want=%h/%h/%h/%h", j,
                 o_grant[j], o_valid[j], o_done[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_addr[j]);
      end
      if (e_valid[j] != '0) begin
        checks++;
        if (o_data[j] !== e_data[j]) begin errors++; $display("FAIL wrap_data cyc=%0d got=%h want=%h", j, o_data[j], e_data[j]); end
      end
      if (o_valid[j] != '0) nvalid++;
    end
    checks++; if (nvalid != 4) begin errors++; $display("FAIL wrap_nvalid got=%0d want=4", nvalid); end
  endtask

  task automatic test_zero_length();
    for (int r = 0; r < 2; r++) begin
      int nbusy = 0;
      set_stim(r == 0 ? 3'b010 : 3'b001, 1'b0, NR, -1);
      t_addr[0] = 10'h155; t_addr[1] = 10'h2AA;
      t_count[0] = 1; t_count[1] = 0;
      model_run(); run_stim();
      for (int j = 1; j <= e_len; j++) begin
        checks++;
        if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
          errors++;
          $display("FAIL zero r=%0d cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", r, j,
                   o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
        end
        if (e_valid[j] != '0) begin
          checks++;
          if (o_data[j] !== e_data[j]) begin errors++; $display("FAIL zero_data cyc=%0d got=%h want=%h", j, o_data[j], e_data[j]); end
        end
        if (o_busy[j] === 1'b1) nbusy++;
      end
      if (r == 0) begin
        checks++; if (nbusy > 1) begin errors++; $display("FAIL zero_busy got=%0d cycles want<=1", nbusy); end
      end
    end
  endtask

  task automatic test_mid_burst();
    set_stim(3'b001, 1'b0, NR, 3);
    t_addr[0] = 10'h0C0; t_count[0] = 8;
    model_run(); run_stim();
    for (int j = 1; j <= e_len; j++) begin
      checks++;
      if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
        errors++;
        $display("FAIL midchg cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", j,
                 o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
      end
      if (e_valid[j] != '0) begin
        checks++;
        if (o_data[j] !== e_data[j]) begin errors++; $display("FAIL midchg_data cyc=%0d got=%h want=%h", j, o_data[j], e_data[j]); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    bus.req_addr[0 +: AW] = 10'h2A0; bus.req_count[0 +: CW] = 8'd6; bus.req = 3'b001;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (bus.data_valid !== 3'b001) begin errors++; $display("FAIL rmb_valid3 got=%h want=001", bus.data_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.grant !== '0)      begin errors++; $display("FAIL rmb_grant got=%h want=0", bus.grant); end
    checks++; if (bus.data_valid !== '0) begin errors++; $display("FAIL rmb_valid got=%h want=0", bus.data_valid); end
    checks++; if (bus.burst_done !== '0) begin errors++; $display("FAIL rmb_done got=%h want=0", bus.burst_done); end
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rmb_busy got=%b want=0", bus.busy); end
    checks++; if (bus.mem_addr !== '0)   begin errors++; $display("FAIL rmb_addr got=%h want=0", bus.mem_addr); end
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_last = NR - 1; m_addr = '0;
    set_stim(3'b011, 1'b0, NR, -1);
    t_addr[0] = 10'h040; t_addr[1] = 10'h080; t_count[0] = 3; t_count[1] = 3;
    model_run(); run_stim();
    checks++; if (o_grant[1] !== 3'b001) begin errors++; $display("FAIL rmb_first got=%h want=001", o_grant[1]); end
    for (int j = 1; j <= e_len; j++) begin
      checks++;
      if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
        errors++;
        $display("FAIL rmb_after cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", j,
                 o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      set_stim(NR'($urandom_range(1, (1 << NR) - 1)), 1'b0, NR, -1);
      for (int i = 0; i < NR; i++) begin
        t_addr[i]  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(1016, 1023)) : AW'($urandom_range(0, 1023));
        t_count[i] = $urandom_range(0, 12);
      end
      model_run(); run_stim();
      for (int j = 1; j <= e_len; j++) begin
        checks++;
        if ({o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j]} !== {e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]}) begin
          errors++;
          $display("FAIL rand it=%0d cyc=%0d grant/valid/done/busy/addr got=%h/%h/%h/%b/%h want=%h/%h/%h/%b/%h", it, j,
                   o_grant[j], o_valid[j], o_done[j], o_busy[j], o_addr[j], e_grant[j], e_valid[j], e_done[j], e_busy[j], e_addr[j]);
        end
        if (e_valid[j] != '0) begin
          checks++;
          if (o_data[j] !== e_data[j]) begin errors++; $display("FAIL rand_data it=%0d cyc=%0d got=%h want=%h", it, j, o_data[j], e_data[j]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.req_addr = '0; bus.req_count = '0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_addr_wrap();
    test_zero_length();
    test_mid_burst();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fc_mem_arbiter.md
Name: fc_mem_arbiter

Overview:
- Shares the single weight/bias memory read port between NUM_REQ burst requesters: the FC DMA, the CNN kernel loader and spare ports.
- Requests are granted round-robin; a granted burst runs to completion and is never preempted.
- Drives mem_addr sequentially and routes returned words to the granted requester with a valid strobe.
- Sits between the requesters' DMA engines and the external memory interface of the top module.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WORD_SIZE, 16, memory word width.
- MEM_ADDRESS_WIDTH, 10, memory address width.
- COUNT_WIDTH, 8, burst length field width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester level request.
- req_addr  in  NUM_REQ*MEM_ADDRESS_WIDTH  base address; requester i uses bits [i*MEM_ADDRESS_WIDTH +: MEM_ADDRESS_WIDTH].
- req_count  in  NUM_REQ*COUNT_WIDTH  burst length in words; requester i uses bits [i*COUNT_WIDTH +: COUNT_WIDTH].
- grant  out  NUM_REQ  one-hot owner of the port; all zero when idle.
- data_valid  out  NUM_REQ  one-hot strobe: data holds a word for that requester.
- data  out  WORD_SIZE  combinational pass-through of mem_data.
- burst_done  out  NUM_REQ  one-cycle pulse at the owner's last word.
- busy  out  1  high in BURST or DRAIN.
- mem_addr  out  MEM_ADDRESS_WIDTH  registered read address to memory.
- mem_data  in  WORD_SIZE  memory read data, valid one cycle after mem_addr.

Behaviour:
- Reset (async, mid-burst included): state IDLE; grant, data_valid, burst_done, busy and mem_addr all 0. The round-robin pointer is set to NUM_REQ-1, so requester 0 wins first. No partial burst resumes.
- States: IDLE, BURST, DRAIN.
- IDLE, arbitration when any req is high at edge t:
  - Search order is last_owner+1, +2, ... modulo NUM_REQ; the first requester with req high wins.
  - Latch the winner's req_addr, req_count and index.
  - At t+1: grant[w]=1, mem_addr=base, busy=1, state BURST.
  - last_owner updates to w.
- IDLE, count==0 at grant: grant[w] and burst_done[w] are both high for exactly cycle t+1. No mem_addr change, no data_valid. Return to IDLE at t+2.
- BURST:
  - mem_addr increments by 1 each cycle: base, base+1, ..., base+count-1.
  - Addresses wrap modulo 2^MEM_ADDRESS_WIDTH.
  - data_valid[w] is registered and high the cycle after each address issue.
  - After the last address is issued, go to DRAIN.
- DRAIN (1 cycle):
  - Last data_valid[w] and burst_done[w] are high.
  - grant stays high.
  - Next state IDLE with grant=0.
- Timing for count N≥1, with req seen at edge t:
  - grant t+1 .. t+N+1.
  - Valids at t+2 .. t+N+1; N valids total, back-to-back with no gaps.
  - burst_done at t+N+1.
  - Earliest next grant t+N+3; one idle arbitration cycle is mandatory.
- Sampling: req, req_addr and req_count are sampled only at arbitration. Changes or req deassertion mid-burst are ignored; bursts cannot be aborted except by rst.
- Request hold: a requester whose req is still high after its burst_done is treated as a new request. With others pending, round-robin serves them first.
- Exclusivity: grant, data_valid and burst_done are each one-hot or zero; never more than one bit high.
- Idle outputs: mem_addr holds its last value, except that it is 0 after reset.
- data always equals mem_data. Consumers qualify it with data_valid.

Test Plan:
- Single burst: rst, then req[0]=1, addr=0x010, count=4 (memory word = address) -> grant[0] for 5 cycles; mem_addr 0x010..0x013; data_valid[0] for 4 consecutive cycles with data 0x010..0x013; burst_done[0] on the 4th valid; then grant=0.
- Round-robin fairness: req[0] and req[1] both held high, count=2 each -> grants alternate 0,1,0,1 with one idle cycle between bursts; requester 0 wins first after reset.
- Address wrap: addr=0x3FE, count=4 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001; data_valid count 4.
- Zero-length request: req[1], count=0 -> grant[1] and burst_done[1] for one cycle, no data_valid, busy high for no more than 1 cycle; a following req[0] count=1 is served normally.
- Mid-burst changes: req[0] count=8; drop req and change req_addr after the 2nd valid -> all 8 words delivered from the original addresses.
- Reset mid-burst: assert rst during the 3rd valid of a count=6 burst -> all outputs 0 asynchronously within the same cycle; after release, req[1] and req[0] both high -> requester 0 granted first.
